// File: rtl/pong_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pong_pkg : shared geometry, colours and state encoding for the pong engine
// Rev 1.0
// ----------------------------------------------------------------------------
package pong_pkg;

   localparam logic [9:0] SCR_X_MAX   = 10'd639;
   localparam logic [9:0] SCR_Y_MAX   = 10'd479;
   localparam logic [9:0] FTICK_ROW   = 10'd481;

   localparam logic [9:0] WALL_X_L    = 10'd32;
   localparam logic [9:0] WALL_X_R    = 10'd35;

   localparam logic [9:0] PAD_X_L     = 10'd600;
   localparam logic [9:0] PAD_X_R     = 10'd603;
   localparam logic [9:0] PAD_H_M1    = 10'd71;
   localparam logic [9:0] PAD_T_INIT  = 10'd204;

   localparam logic [9:0] BALL_M1     = 10'd7;
   localparam logic [9:0] BALL_X_INIT = 10'd316;
   localparam logic [9:0] BALL_Y_INIT = 10'd236;
   localparam logic [9:0] BALL_Y_TOP  = 10'd1;
   localparam logic [9:0] BALL_Y_BOT  = 10'd478;

   localparam logic [11:0] COL_BALL   = 12'hF00;
   localparam logic [11:0] COL_PAD    = 12'h0F0;
   localparam logic [11:0] COL_WALL   = 12'h00F;
   localparam logic [11:0] COL_BG     = 12'h000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_MISS = 2'd2
   } state_e;

   function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                     input logic [9:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pong_graphics_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pong_graphics_if : pixel stream, buttons and game outputs of the renderer
// Rev 1.0
// ----------------------------------------------------------------------------
interface pong_graphics_if;
   logic        video_on;
   logic        p_tick;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        btn_up;
   logic        btn_down;
   logic        btn_start;
   logic [11:0] rgb;
   logic        hit;
   logic        miss;
   logic [1:0]  state;

   modport master (
      output video_on, p_tick, x, y, btn_up, btn_down, btn_start,
      input  rgb, hit, miss, state
   );

   modport slave (
      input  video_on, p_tick, x, y, btn_up, btn_down, btn_start,
      output rgb, hit, miss, state
   );
endinterface
`default_nettype wire

// File: rtl/pong_ball_rom.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pong_ball_rom : combinational 8x8 round ball bitmap
// Rev 1.0
// ----------------------------------------------------------------------------
module pong_ball_rom (
   input  logic [2:0] row,
   input  logic [2:0] col,
   output logic       pix_bit
);

   logic [7:0] line;

   // The bitmap is mirror-symmetric, so column bit order does not matter.
   always_comb begin
      case (row)
         3'd0, 3'd7: line = 8'b00111100;
         3'd1, 3'd6: line = 8'b01111110;
         default:    line = 8'b11111111;
      endcase
      pix_bit = line[col];
   end

endmodule
`default_nettype wire

// File: rtl/pong_graphics.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pong_graphics : pixel renderer plus per-frame wall/paddle/ball game engine
// Rev 1.0
// ----------------------------------------------------------------------------
module pong_graphics
   import pong_pkg::*;
#(
   parameter int BALL_V      = 2,
   parameter int PAD_V       = 4,
   parameter int HOLD_FRAMES = 60
) (
   input  logic           clk,
   input  logic           reset,
   pong_graphics_if.slave gfx
);

   localparam logic [9:0] BV        = 10'(BALL_V);
   localparam logic [9:0] PV        = 10'(PAD_V);
   localparam logic [5:0] HOLD_LAST = 6'(HOLD_FRAMES - 1);

   state_e      state_q, state_d;
   logic [9:0]  pad_t_q, pad_t_d;
   logic [9:0]  bx_q, bx_d;
   logic [9:0]  by_q, by_d;
   logic        vx_pos_q, vx_pos_d;
   logic        vy_pos_q, vy_pos_d;
   logic [5:0]  hold_cnt_q, hold_cnt_d;
   logic        hit_q, hit_d;
   logic        miss_q, miss_d;
   logic [11:0] rgb_q, rgb_d;

   logic        ftick;
   logic [9:0]  bx_r, by_b, pad_b;
   logic        ball_box, ball_bit;
   logic [2:0]  ball_row, ball_col;

   assign ftick = gfx.p_tick && (gfx.x == 10'd0) && (gfx.y == FTICK_ROW);
   assign bx_r  = bx_q + BALL_M1;
   assign by_b  = by_q + BALL_M1;
   assign pad_b = pad_t_q + PAD_H_M1;

   always_comb begin
      pad_t_d = pad_t_q;
      if (ftick) begin
         if (gfx.btn_up && !gfx.btn_down && (pad_t_q > PV))
            pad_t_d = pad_t_q - PV;
         else if (gfx.btn_down && !gfx.btn_up && (pad_b < SCR_Y_MAX - PV))
            pad_t_d = pad_t_q + PV;
      end
   end

   always_comb begin
      state_d    = state_q;
      bx_d       = bx_q;
      by_d       = by_q;
      vx_pos_d   = vx_pos_q;
      vy_pos_d   = vy_pos_q;
      hold_cnt_d = hold_cnt_q;
      hit_d      = 1'b0;
      miss_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bx_d     = BALL_X_INIT;
            by_d     = BALL_Y_INIT;
            vx_pos_d = 1'b1;
            vy_pos_d = 1'b0;
            if (ftick && gfx.btn_start)
               state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (ftick) begin
               if (bx_r > SCR_X_MAX) begin
                  miss_d     = 1'b1;
                  state_d    = ST_MISS;
                  hold_cnt_d = 6'd0;
               end else begin
                  // Bounces are judged on the current position; the new
                  // velocity then moves the ball in the same tick.
                  if (by_q <= BALL_Y_TOP)
                     vy_pos_d = 1'b1;
                  else if (by_b >= BALL_Y_BOT)
                     vy_pos_d = 1'b0;
                  if (bx_q <= WALL_X_R) begin
                     vx_pos_d = 1'b1;
                  end else if (in_range(bx_r, PAD_X_L, PAD_X_R) &&
                               (by_b >= pad_t_q) && (by_q <= pad_b)) begin
                     vx_pos_d = 1'b0;
                     hit_d    = 1'b1;
                  end
                  bx_d = vx_pos_d ? bx_q + BV : bx_q - BV;
                  by_d = vy_pos_d ? by_q + BV : by_q - BV;
               end
            end
         end
         ST_MISS: begin
            if (ftick) begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_d    = ST_IDLE;
                  hold_cnt_d = 6'd0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 6'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ball_box = (state_q == ST_PLAY) &&
                     in_range(gfx.x, bx_q, bx_r) && in_range(gfx.y, by_q, by_b);
   assign ball_row = 3'(gfx.y - by_q);
   assign ball_col = 3'(gfx.x - bx_q);

   pong_ball_rom u_ball_rom (
      .row     (ball_row),
      .col     (ball_col),
      .pix_bit (ball_bit)
   );

   always_comb begin
      rgb_d = COL_BG;
      if (gfx.video_on) begin
         if (ball_box && ball_bit)
            rgb_d = COL_BALL;
         else if (in_range(gfx.x, PAD_X_L, PAD_X_R) && in_range(gfx.y, pad_t_q, pad_b))
            rgb_d = COL_PAD;
         else if (in_range(gfx.x, WALL_X_L, WALL_X_R))
            rgb_d = COL_WALL;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pad_t_q    <= PAD_T_INIT;
         bx_q       <= BALL_X_INIT;
         by_q       <= BALL_Y_INIT;
         vx_pos_q   <= 1'b1;
         vy_pos_q   <= 1'b0;
         hold_cnt_q <= 6'd0;
         hit_q      <= 1'b0;
         miss_q     <= 1'b0;
         rgb_q      <= COL_BG;
      end else begin
         state_q    <= state_d;
         pad_t_q    <= pad_t_d;
         bx_q       <= bx_d;
         by_q       <= by_d;
         vx_pos_q   <= vx_pos_d;
         vy_pos_q   <= vy_pos_d;
         hold_cnt_q <= hold_cnt_d;
         hit_q      <= hit_d;
         miss_q     <= miss_d;
         rgb_q      <= rgb_d;
      end
   end

   assign gfx.rgb   = rgb_q;
   assign gfx.hit   = hit_q;
   assign gfx.miss  = miss_q;
   assign gfx.state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_graphics.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pong_graphics : stimulus and reference model for pong_graphics
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pong_graphics;

   localparam int BV   = 2;
   localparam int PV   = 4;
   localparam int HOLD = 60;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pong_graphics_if gfx();

   pong_graphics #(.BALL_V(BV), .PAD_V(PV), .HOLD_FRAMES(HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .gfx   (gfx)
   );

   int errors = 0;
   int checks = 0;
   int dut_hits = 0;

   // Game state kept as plain integers with signed velocities.
   int m_st, m_pad, m_bx, m_by, m_vx, m_vy, m_cnt, m_hits;
   bit m_hit, m_miss;

   typedef struct {
      int          x;
      int          y;
      bit          von;
      logic [11:0] exp;
   } pix_vec_t;
   pix_vec_t tbl [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic ball_home();
      m_bx = 316; m_by = 236; m_vx = BV; m_vy = -BV;
   endtask

   task automatic model_reset();
      m_st = 0; m_pad = 204; m_cnt = 0;
      ball_home();
   endtask

   function automatic logic [11:0] exp_rgb(input int x, input int y, input bit von);
      int dr, dc;
      if (!von) return 12'h000;
      if (m_st == 1 && x >= m_bx && x <= m_bx + 7 && y >= m_by && y <= m_by + 7) begin
         // Pixel centres inside a radius-4 circle form the round ball.
         dr = 2 * (y - m_by) - 7;
         dc = 2 * (x - m_bx) - 7;
         if (dr * dr + dc * dc <= 64) return 12'hF00;
      end
      if (x >= 600 && x <= 603 && y >= m_pad && y <= m_pad + 71) return 12'h0F0;
      if (x >= 32 && x <= 35) return 12'h00F;
      return 12'h000;
   endfunction

   task automatic model_tick(input bit up, input bit down, input bit start);
      int pad0;
      pad0   = m_pad;
      m_hit  = 1'b0;
      m_miss = 1'b0;
      if (up && !down && m_pad > PV) m_pad -= PV;
      else if (down && !up && m_pad + 71 < 479 - PV) m_pad += PV;
      case (m_st)
         0: begin
            ball_home();
            if (start) m_st = 1;
         end
         1: begin
            if (m_bx + 7 > 639) begin
               m_miss = 1'b1; m_st = 2; m_cnt = 0;
            end else begin
               if (m_by <= 1) m_vy = BV;
               else if (m_by + 7 >= 478) m_vy = -BV;
               if (m_bx <= 35) m_vx = BV;
               else if (m_bx + 7 >= 600 && m_bx + 7 <= 603 &&
                        m_by + 7 >= pad0 && m_by <= pad0 + 71) begin
                  m_vx = -BV; m_hit = 1'b1; m_hits++;
               end
               m_bx += m_vx;
               m_by += m_vy;
            end
         end
         default: begin
            m_cnt++;
            if (m_cnt == HOLD) begin m_st = 0; ball_home(); end
         end
      endcase
   endtask

   task automatic drive(input int x, input int y, input bit von, input bit pt);
      gfx.x        = 10'(x);
      gfx.y        = 10'(y);
      gfx.video_on = von;
      gfx.p_tick   = pt;
   endtask

   task automatic probe_exp(input int x, input int y, input bit von, input logic [11:0] exp,
                            input string name);
      @(negedge clk);
      drive(x, y, von, 1'($urandom_range(1)));
      gfx.btn_up    = 1'($urandom_range(1));
      gfx.btn_down  = 1'($urandom_range(1));
      gfx.btn_start = 1'($urandom_range(1));
      @(posedge clk); #1;
      check(name, gfx.rgb, exp);
   endtask

   task automatic probe(input int x, input int y, input bit von);
      probe_exp(x, y, von, exp_rgb(x, y, von), "rgb");
   endtask

   task automatic probes();
      probe(m_bx + 3, m_by + 4, 1'b1);
      probe(m_bx, m_by, 1'b1);
      probe(601, m_pad, 1'b1);
      probe(602, m_pad - 1, 1'b1);
      probe(603, m_pad + 71, 1'b1);
      probe(600, m_pad + 72, 1'b1);
      probe($urandom_range(639), $urandom_range(479), 1'($urandom_range(1)));
      // Frame-tick row with p_tick low must not count as a tick.
      @(negedge clk);
      drive(0, 481, 1'b0, 1'b0);
      gfx.btn_up = 1'b1; gfx.btn_down = 1'b0; gfx.btn_start = 1'b1;
      @(posedge clk); #1;
      check("no_tick_state", gfx.state, 32'(m_st));
   endtask

   task automatic frame(input bit up, input bit down, input bit start);
      @(negedge clk);
      drive(0, 481, 1'b0, 1'b1);
      gfx.btn_up = up; gfx.btn_down = down; gfx.btn_start = start;
      @(posedge clk); #1;
      model_tick(up, down, start);
      if (gfx.hit === 1'b1) dut_hits++;
      check("hit", gfx.hit, 32'(m_hit));
      check("miss", gfx.miss, 32'(m_miss));
      check("state", gfx.state, 32'(m_st));
      @(negedge clk);
      drive(1, 481, 1'b0, 1'b1);
      gfx.btn_up = ~up; gfx.btn_down = ~down; gfx.btn_start = ~start;
      @(posedge clk); #1;
      check("hit_width", gfx.hit, 32'd0);
      check("miss_width", gfx.miss, 32'd0);
   endtask

   task automatic track_frame(input bit with_probes);
      int tgt;
      bit up, dn;
      tgt = m_by - 32;
      up  = m_pad > tgt + 2;
      dn  = m_pad < tgt - 2;
      if ($urandom_range(15) == 0) begin up = 1'b1; dn = 1'b1; end
      frame(up, dn, 1'b0);
      if (with_probes) probes();
   endtask

   initial begin
      tbl[0]  = '{601, 240, 1'b1, 12'h0F0};
      tbl[1]  = '{33,  10,  1'b1, 12'h00F};
      tbl[2]  = '{601, 240, 1'b0, 12'h000};
      tbl[3]  = '{33,  10,  1'b0, 12'h000};
      tbl[4]  = '{300, 300, 1'b1, 12'h000};
      tbl[5]  = '{603, 204, 1'b1, 12'h0F0};
      tbl[6]  = '{603, 203, 1'b1, 12'h000};
      tbl[7]  = '{600, 275, 1'b1, 12'h0F0};
      tbl[8]  = '{600, 276, 1'b1, 12'h000};
      tbl[9]  = '{31,  0,   1'b1, 12'h000};
      tbl[10] = '{36,  479, 1'b1, 12'h000};
      tbl[11] = '{32,  479, 1'b1, 12'h00F};
      tbl[12] = '{604, 250, 1'b1, 12'h000};
      tbl[13] = '{320, 240, 1'b1, 12'h000};

      reset = 1'b1;
      drive(5, 5, 1'b0, 1'b0);
      gfx.btn_up = 1'b0; gfx.btn_down = 1'b0; gfx.btn_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      check("reset_rgb", gfx.rgb, 32'h0);
      check("reset_hit", gfx.hit, 32'h0);
      check("reset_miss", gfx.miss, 32'h0);
      check("reset_state", gfx.state, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      frame(1'b0, 1'b0, 1'b0);
      foreach (tbl[i]) probe_exp(tbl[i].x, tbl[i].y, tbl[i].von, tbl[i].exp, "idle_pixel");

      repeat (60) begin frame(1'b1, 1'b0, 1'b0); probes(); end
      probe_exp(601, 4, 1'b1, 12'h0F0, "pad_top_limit");
      probe_exp(601, 3, 1'b1, 12'h000, "pad_top_above");
      repeat (110) begin frame(1'b0, 1'b1, 1'b0); probes(); end
      probe_exp(601, 475, 1'b1, 12'h0F0, "pad_bot_limit");
      probe_exp(601, 476, 1'b1, 12'h000, "pad_bot_below");
      repeat (5) begin frame(1'b1, 1'b1, 1'b0); probes(); end
      probe_exp(601, 404, 1'b1, 12'h0F0, "pad_both_hold");
      probe_exp(601, 403, 1'b1, 12'h000, "pad_both_above");

      frame(1'b0, 1'b0, 1'b1);
      check("start_state", gfx.state, 32'd1);
      frame(1'b0, 1'b0, 1'b0);
      probe_exp(321, 238, 1'b1, 12'hF00, "ball_centre");
      probe_exp(318, 234, 1'b1, 12'h000, "ball_corner");
      probes();

      for (int f = 0; f < 700; f++) track_frame(1'b1);
      check("hit_count", 32'(dut_hits), 32'(m_hits));

      // Keep the paddle in the half away from the ball until it escapes.
      for (int f = 0; f < 1500 && m_st != 2; f++) begin
         bit up;
         up = (m_by + 4 >= 240);
         frame(up, !up, 1'b0);
         if (f % 4 == 0) probes();
      end
      check("reached_miss", gfx.state, 32'd2);

      for (int f = 0; f < HOLD; f++) begin
         frame(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
         probes();
      end
      check("miss_hold_done", gfx.state, 32'd0);

      frame(1'b0, 1'b0, 1'b1);
      frame(1'b0, 1'b0, 1'b0);
      probe_exp(321, 238, 1'b1, 12'hF00, "ball_rehome");

      // Drive the ball to the tick that would register a paddle hit, then reset there.
      for (int f = 0; f < 400 && m_bx != 594; f++) track_frame(1'b0);
      check("pre_reset_state", gfx.state, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      drive(0, 481, 1'b1, 1'b1);
      gfx.btn_up = 1'b1; gfx.btn_down = 1'b0; gfx.btn_start = 1'b1;
      @(posedge clk); #1;
      check("rst_hit", gfx.hit, 32'h0);
      check("rst_miss", gfx.miss, 32'h0);
      check("rst_state", gfx.state, 32'h0);
      check("rst_rgb", gfx.rgb, 32'h0);
      @(negedge clk);
      drive(33, 100, 1'b1, 1'b0);
      @(posedge clk); #1;
      check("rst_rgb_hold", gfx.rgb, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      probe_exp(601, 204, 1'b1, 12'h0F0, "post_rst_pad");
      probe_exp(601, 203, 1'b1, 12'h000, "post_rst_pad_above");
      frame(1'b0, 1'b0, 1'b0);
      probes();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pong_graphics.md
# pong_graphics

Pixel renderer and game-object engine for the ping-pong game. It consumes the VGA timing generator's pixel coordinates, `video_on` and `p_tick`, and maintains wall, paddle and ball state that updates once per frame. It produces the 12-bit RGB value for the current pixel, registered to align with the generator's registered `hsync`/`vsync`. It also reports hit and miss events to the score/control logic.

## Interface
**Parameters**
- `BALL_V`, 2: ball speed per frame on each axis, in pixels.
- `PAD_V`, 4: paddle speed per frame, in pixels.
- `HOLD_FRAMES`, 60: number of frames spent in MISS before returning to IDLE.

**Ports**
- `clk`, input, 1: system clock, same as the timing generator.
- `reset`, input, 1: synchronous, active-high.
- `video_on`, input, 1: pixel lies in the visible area.
- `p_tick`, input, 1: pixel enable, one clock in two.
- `x`, input, 10: current pixel column.
- `y`, input, 10: current pixel row.
- `btn_up`, input, 1: move paddle up; level input, already debounced.
- `btn_down`, input, 1: move paddle down; level input.
- `btn_start`, input, 1: serve the ball; level input.
- `rgb`, output, 12: registered pixel colour, {R[3:0], G[3:0], B[3:0]}.
- `hit`, output, 1: one-clock pulse when the ball bounces off the paddle.
- `miss`, output, 1: one-clock pulse when the ball leaves the right edge.
- `state`, output, 2: 0 = IDLE, 1 = PLAY, 2 = MISS.

## Operation
- **Frame tick:** `ftick = p_tick && x == 0 && y == 481`. It is high for exactly one clock per frame. All motion updates happen only on `ftick`.
- **Geometry:** all coordinates are 10-bit unsigned and inclusive.
  - Wall occupies x 32..35 for all y.
  - Paddle occupies x 600..603 and y `pad_t`..`pad_t+71`.
  - Ball is an 8×8 box at x `bx`..`bx+7`, y `by`..`by+7`, masked by a round 8×8 bitmap.
- **Paddle movement (on `ftick`, in every state):**
  - If `btn_up` and not `btn_down` and `pad_t > PAD_V`: `pad_t -= PAD_V`.
  - If `btn_down` and not `btn_up` and `pad_t + 71 < 479 - PAD_V`: `pad_t += PAD_V`.
  - Otherwise `pad_t` holds, including when both buttons are pressed.
- **FSM:**
  - **IDLE:** ball hidden; `bx = 316`, `by = 236`, `vx = +BALL_V`, `vy = -BALL_V`. On `ftick` with `btn_start` high, go to PLAY.
  - **PLAY:** on `ftick`, first evaluate bounces against the current position, then add velocity.
    - Bounce rules:
      - `by <= 1` sets `vy = +V`.
      - `by + 7 >= 478` sets `vy = -V`.
      - `bx <= 35` sets `vx = +V`.
      - `bx + 7` in 600..603 with y overlapping the paddle sets `vx = -V` and pulses `hit`.
    - If `bx + 7 > 639`, pulse `miss` and go to MISS without moving.
    - If both a vertical bounce and a horizontal bounce apply, both take effect.
  - **MISS:** ball hidden. A 6-bit frame counter is cleared on entry. After `HOLD_FRAMES` ftick cycles, go to IDLE.
- **Colour priority:** ball (`12'hF00`, only where the ROM bit is 1) > paddle (`12'h0F0`) > wall (`12'h00F`) > background (`12'h000`). The ball is drawn only in PLAY.
- When `video_on` is 0, `rgb` is forced to 0.

## Timing
- `rgb` is updated every clock from the current `x`, `y` and `video_on`, giving 1 clock of latency. This matches the generator's registered sync outputs.
- `hit` and `miss` assert in the clock after the `ftick` that detects the event and are high for exactly 1 clock.
- `state` updates in the clock after `ftick`.
- **Reset values:**
  - `rgb = 0`, `hit = 0`, `miss = 0`, `state = IDLE`.
  - `pad_t = 204`, `bx = 316`, `by = 236`, `vx = +BALL_V`, `vy = -BALL_V`, frame counter = 0.
- Reset asserted mid-frame or mid-MISS returns everything to the reset values on the next clock edge, with no pulses emitted.
- Buttons are sampled only at `ftick`. Presses that occur between ticks are ignored.

## Structure
- A shared package `pong_pkg` holds:
  - the geometry localparams (wall, paddle and ball bounds, screen limits 639/479, frame-tick row 481);
  - the colour constants;
  - the state encoding IDLE/PLAY/MISS.
- Sub-module `pong_ball_rom`: a combinational 8×8 round bitmap. Inputs are `row[2:0]` and `col[2:0]`; output is `bit`. Row 0 is `8'b00111100` and the bitmap is symmetric.

## Test plan
- Reset, then one full frame with no buttons → `state = 0`, `pad_t = 204`. Pixel (601, 240) gives `rgb = 0F0` one clock later; pixel (33, 10) gives `00F`; any pixel with `video_on = 0` gives `000`.
- Hold `btn_up` for 60 frames → `pad_t` decreases by 4 per frame and stops at 4, never wrapping. Hold `btn_down` → `pad_t` stops at 404 (`pad_t + 71 <= 475`). Both buttons together → no change.
- `btn_start` at `ftick` → PLAY. After 1 frame, `bx = 318` and `by = 234`. The ball pixel at the centre gives `F00`; the corner pixel (`bx`, `by`) gives background.
- Force a trajectory with `pad_t = by - 10` and `bx + 7` reaching 600 → `hit` pulses once and `vx` becomes −2. Force `by = 1` → `vy` becomes +2 with no pulse.
- Paddle moved away from the ball path → `miss` pulses once and the state goes to MISS. Exactly 60 frames later the state is IDLE and the ball is back at (316, 236).
- Assert `reset` during PLAY mid-line → next clock shows all reset values and no `hit`/`miss` pulse.
